// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, owner codes and default limits for the memory port arbiter
package cpu_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_e;
  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: clearable cycle counter that flags when a wait has lasted TIMEOUT cycles
module arb_watchdog import cpu_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction and data ports,
// data first, with a starvation bound for fetch and a watchdog on unacknowledged accesses.
module mem_port_arbiter import cpu_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_e state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic owner_q, we_q, mem_req_q, busy_q, i_ready_q, d_ready_q, i_err_q, d_err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic idle, gnt_d, gnt_i, grant, wd_exp, finish;
  assign idle = state_q == ARB_IDLE;
  assign gnt_d = idle && d_req && (!i_req || starve_q < SW'(STARVE_LIMIT));
  assign gnt_i = idle && i_req && !gnt_d;
  assign grant = gnt_d || gnt_i;
  // ack beats an expiring watchdog because both simply end the wait here
  assign finish = state_q == ARB_BUSY && (mem_ack || wd_exp);
  always_comb begin
    state_d = state_q;
    starve_d = starve_q;
    if (idle) begin
      state_d = grant ? ARB_BUSY : ARB_IDLE;
      starve_d = (!i_req || gnt_i) ? '0 : starve_q + SW'(starve_q != SW'(STARVE_LIMIT));
    end else if (finish) state_d = ARB_DONE;
    else if (state_q == ARB_DONE) state_d = ARB_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      starve_q <= '0;
      owner_q <= OWN_D;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mem_req_q <= 1'b0;
      busy_q <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      mem_req_q <= state_d == ARB_BUSY;
      busy_q <= state_d != ARB_IDLE;
      i_ready_q <= finish && owner_q == OWN_I;
      d_ready_q <= finish && owner_q == OWN_D;
      i_err_q <= finish && !mem_ack && owner_q == OWN_I;
      d_err_q <= finish && !mem_ack && owner_q == OWN_D;
      if (finish) rdata_q <= (mem_ack && !we_q) ? mem_rdata : '0;
      if (grant) begin
        owner_q <= gnt_i ? OWN_I : OWN_D;
        we_q <= gnt_d && d_we;
        addr_q <= gnt_d ? d_addr : i_addr;
        wdata_q <= gnt_d ? d_wdata : '0;
      end
    end
  end
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (grant),
    .en_i      (state_q == ARB_BUSY),
    .expired_o (wd_exp)
  );
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_err = i_err_q;
  assign d_err = d_err_q;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;
  assign mem_req = mem_req_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign busy = busy_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and memory against a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;
  logic clk, rst;
  logic i_req, i_ready, i_err, d_req, d_we, d_ready, d_err;
  logic mem_req, mem_we, mem_ack, busy, owner;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit i_pend, d_pend, dw, last_own;
  logic [31:0] i_a, da, dwd;
  int d_streak;
  logic [31:0] mem [logic [31:0]];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction
  // One arbitration opportunity starting in an idle cycle; ack_at = BUSY cycle of ack, 0 = never
  task automatic round(input int ack_at);
    bit gd, gi, own, ewe, hit, err;
    logic [31:0] ea, ewd, erd;
    i_req = i_pend; i_addr = i_a;
    d_req = d_pend; d_we = dw; d_addr = da; d_wdata = dwd;
    mem_ack = $urandom_range(0, 3) == 0; mem_rdata = $urandom;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_mreq", mem_req, 0);
    check("idle_owner", owner, last_own);
    check("idle_ready", {i_ready, d_ready}, 0);
    gd = d_pend && (!i_pend || d_streak < SL);
    gi = i_pend && !gd;
    d_streak = (i_pend && gd) ? d_streak + 1 : 0;
    @(posedge clk); #1;
    if (!gd && !gi) return;
    own = gi; last_own = own;
    ea = gi ? i_a : da; ewe = gd && dw; ewd = dwd;
    erd = ewe ? 32'h0 : rd_mem(ea);
    if (gd) begin d_addr = $urandom; d_wdata = $urandom; end
    else i_addr = $urandom;
    hit = 0;
    for (int c = 1; c <= TO; c++) begin
      hit = c == ack_at;
      mem_ack = hit; mem_rdata = (hit && !ewe) ? erd : $urandom;
      @(negedge clk);
      check("busy_mreq", mem_req, 1);
      check("busy_busy", busy, 1);
      check("busy_owner", owner, own);
      check("busy_maddr", mem_addr, ea);
      check("busy_mwe", mem_we, ewe);
      if (ewe) check("busy_mwdata", mem_wdata, ewd);
      check("busy_ready", {i_ready, d_ready}, 0);
      @(posedge clk); #1;
      if (hit) break;
    end
    err = !hit;
    if (hit && ewe) mem[ea] = ewd;
    if (err) erd = 32'h0;
    mem_ack = $urandom_range(0, 1); mem_rdata = $urandom;
    @(negedge clk);
    check("done_mreq", mem_req, 0);
    check("done_busy", busy, 1);
    check("done_i_ready", i_ready, own);
    check("done_d_ready", d_ready, !own);
    check("done_rdata", own ? i_rdata : d_rdata, erd);
    check("done_err", own ? i_err : d_err, err);
    check("done_other_err", own ? d_err : i_err, 0);
    @(posedge clk); #1;
    if (own) i_pend = 0; else d_pend = 0;
    i_req = i_pend; d_req = d_pend; mem_ack = 0;
  endtask
  initial begin
    bit [5:0] seq;
    rst = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    i_pend = 0; d_pend = 0; dw = 0; i_a = 0; da = 0; dwd = 0; last_own = 0; d_streak = 0;
    #3;
    check("rst_outputs", {mem_req, mem_we, busy, owner, i_ready, d_ready, i_err, d_err}, 0);
    check("rst_maddr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    mem[32'h40] = 32'h2002000A;
    i_pend = 1; i_a = 32'h40;
    round(1);
    d_pend = 1; dw = 1; da = 32'h100; dwd = 32'hDEADBEEF;
    i_pend = 1; i_a = 32'h44;
    round(1);
    check("simul_first_d", last_own, 0);
    round(1);
    check("simul_second_i", last_own, 1);
    d_pend = 1; dw = 0; da = 32'h100;
    round(2);
    round(1);
    i_pend = 1; i_a = 32'h48;
    for (int r = 0; r < 6; r++) begin
      d_pend = 1; dw = r[0]; da = 32'(r) << 2; dwd = $urandom;
      if (r == 5) begin i_pend = 1; i_a = 32'h4C; end
      round(1);
      seq[r] = last_own;
    end
    check("starve_seq", seq, 6'b010000);
    i_pend = 0;
    d_pend = 1; dw = 0; da = 32'h8;
    round(0);
    d_pend = 1; dw = 1; da = 32'h8; dwd = 32'hCAFEF00D;
    round(3);
    i_pend = 1; i_a = 32'h8;
    round(TO);
    for (int n = 0; n < 150; n++) begin
      int r;
      if (!i_pend && $urandom_range(0, 9) < 6) begin i_pend = 1; i_a = 32'($urandom_range(0, 15)) << 2; end
      if (!d_pend && $urandom_range(0, 9) < 7) begin
        d_pend = 1; dw = $urandom_range(0, 1); da = 32'($urandom_range(0, 15)) << 2; dwd = $urandom;
      end
      r = $urandom_range(0, 9);
      round(r == 0 ? 0 : r == 1 ? TO : $urandom_range(1, 4));
    end
    i_pend = 0; d_pend = 0;
    round(1);
    i_req = 1; i_addr = 32'h80; d_req = 0; mem_ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstb_pre_mreq", mem_req, 1);
    check("rstb_pre_owner", owner, 1);
    #1 rst = 0;
    #1;
    check("rstb_mreq", mem_req, 0);
    check("rstb_busy", busy, 0);
    check("rstb_owner", owner, 0);
    check("rstb_ready", {i_ready, d_ready}, 0);
    @(posedge clk); #1;
    i_req = 0; mem_ack = 1; mem_rdata = $urandom; rst = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstb_after_ready", {i_ready, d_ready, i_err, d_err}, 0);
      check("rstb_after_mreq", {mem_req, busy}, 0);
      @(posedge clk); #1;
      mem_ack = 0;
    end
    last_own = 0; d_streak = 0;
    d_pend = 1; dw = 0; da = 32'h100;
    round(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
